tune_ctrl: RTL and testbench

TUNE_CTRL -- requirements
Module: tune_ctrl

---
 rtl/tune_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tune_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tune_ctrl.sv
// Frequency tuning controller: encoder steps adjust a saturating accumulator; results go to the NCO over a req/ack handshake.
// Optional step acceleration is enabled by defining TUNE_ACCEL_EN.
module tune_ctrl #(
    parameter int unsigned FREQ_INIT = 7000000,
    parameter int unsigned FREQ_MIN  = 100000,
    parameter int unsigned FREQ_MAX  = 30000000,
    parameter int unsigned ACCEL_WIN = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt,
    input  logic        dir,
    input  logic        sw_tog,
    output logic [31:0] freq_out,
    output logic        upd_req,
    input  logic        upd_ack,
    output logic [2:0]  step_idx,
    output logic        accel_on
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [32:0] MAX33 = 33'(FREQ_MAX);
    localparam logic [32:0] MIN33 = 33'(FREQ_MIN);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        capture;
    logic        dirty;
    logic        sw_prev;
    logic [31:0] freq_acc;
    logic [31:0] acc_next;
    logic [31:0] table_step;
    logic [31:0] eff_step;
    logic [32:0] sum_inc;
    logic [32:0] sum_dec;

    always_comb begin
        table_step = 32'd1;
        case (step_idx)
            3'd0: table_step = 32'd1;
            3'd1: table_step = 32'd10;
            3'd2: table_step = 32'd100;
            3'd3: table_step = 32'd1000;
            3'd4: table_step = 32'd10000;
            3'd5: table_step = 32'd100000;
            3'd6: table_step = 32'd1000000;
            3'd7: table_step = 32'd10000000;
            default: table_step = 32'd1;
        endcase
    end

`ifdef TUNE_ACCEL_EN
    logic [2:0]  run;
    logic [2:0]  run_next;
    logic [31:0] timer;
    logic        last_dir;

    // The step of the cnt that completes a run of four already uses the x8 size.
    always_comb begin
        run_next = run;
        if (cnt) begin
            if ((dir == last_dir) && (timer < ACCEL_WIN)) begin
                run_next = (run == 3'd4) ? 3'd4 : run + 3'd1;
            end else begin
                run_next = 3'd1;
            end
        end else if (timer >= ACCEL_WIN) begin
            run_next = '0;
        end
    end

    // Timer starts at 1 on a cnt so it holds the edge distance to the next cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= '0;
            timer    <= '0;
            last_dir <= 1'b0;
        end else begin
            run <= run_next;
            if (cnt) begin
                timer    <= 32'd1;
                last_dir <= dir;
            end else if (timer < ACCEL_WIN) begin
                timer <= timer + 32'd1;
            end
        end
    end

    assign eff_step = (run_next == 3'd4) ? (table_step << 3) : table_step;
    assign accel_on = (run == 3'd4);
`else
    assign eff_step = table_step;
    assign accel_on = 1'b0;
`endif

    assign sum_inc = {1'b0, freq_acc} + {1'b0, eff_step};
    assign sum_dec = {1'b0, freq_acc} - {1'b0, eff_step};

    always_comb begin
        acc_next = freq_acc;
        if (dir) begin
            acc_next = (sum_inc > MAX33) ? 32'(FREQ_MAX) : sum_inc[31:0];
        end else begin
            acc_next = (sum_dec[32] || (sum_dec < MIN33)) ? 32'(FREQ_MIN) : sum_dec[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_acc <= 32'(FREQ_INIT);
            step_idx <= 3'd3;
            sw_prev  <= 1'b0;
        end else begin
            if (cnt) begin
                freq_acc <= acc_next;
            end
            if (sw_tog != sw_prev) begin
                step_idx <= step_idx + 3'd1;
            end
            sw_prev <= sw_tog;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dirty) begin
                    state_next = ST_REQ;
                    capture    = 1'b1;
                end
            end
            ST_REQ: begin
                if (upd_ack) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dirty) begin
                    state_next = ST_REQ;
                    capture    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A cnt on the capture edge keeps dirty set, since its result is not in this capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dirty    <= 1'b1;
            freq_out <= 32'(FREQ_INIT);
        end else begin
            state <= state_next;
            dirty <= cnt | (dirty & ~capture);
            if (capture) begin
                freq_out <= freq_acc;
            end
        end
    end

    assign upd_req = (state == ST_REQ);

endmodule

// File: tb/tb_tune_ctrl.sv
// Self-checking bench for tune_ctrl: directed table, handshake sequences and randomized traffic against a reference model.
// Acceleration checks are active when TUNE_ACCEL_EN is defined.
module tb_tune_ctrl;

    localparam longint F_INIT = 7000000;
    localparam longint F_MIN  = 100000;
    localparam longint F_MAX  = 30000000;
    localparam longint WIN    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt;
    logic        dir;
    logic        sw_tog;
    logic [31:0] freq_out;
    logic        upd_req;
    logic        upd_ack;
    logic [2:0]  step_idx;
    logic        accel_on;

    int checks   = 0;
    int failures = 0;

    // reference model state
    longint m_acc, m_pub, cyc, last_cnt;
    int     m_idx, m_run;
    bit     m_req, m_pending, have_prev, m_last_dir, exp_accel, sw_lvl;

    tune_ctrl #(
        .FREQ_INIT(7000000),
        .FREQ_MIN (100000),
        .FREQ_MAX (30000000),
        .ACCEL_WIN(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .dir     (dir),
        .sw_tog  (sw_tog),
        .freq_out(freq_out),
        .upd_req (upd_req),
        .upd_ack (upd_ack),
        .step_idx(step_idx),
        .accel_on(accel_on)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = F_INIT; m_pub = F_INIT; m_idx = 3; m_req = 1'b0; m_pending = 1'b1;
        cyc = 0; last_cnt = 0; m_run = 0; have_prev = 1'b0; m_last_dir = 1'b0; exp_accel = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit d, input bit t, input bit a);
        longint sz, nxt;
        bit cap;
        cyc++;
        cap = !m_req && m_pending;
        if (cap) m_pub = m_acc;
        m_req     = m_req ? !a : m_pending;
        m_pending = cap ? c : (m_pending || c);
        if (c) begin
            sz = 1;
            for (int i = 0; i < m_idx; i++) sz = sz * 10;
`ifdef TUNE_ACCEL_EN
            if (have_prev && d == m_last_dir && (cyc - last_cnt) < WIN)
                m_run = (m_run >= 4) ? 4 : m_run + 1;
            else
                m_run = 1;
            have_prev = 1'b1; m_last_dir = d; last_cnt = cyc;
            if (m_run == 4) sz = sz * 8;
`endif
            nxt = d ? m_acc + sz : m_acc - sz;
            if (nxt > F_MAX) nxt = F_MAX;
            if (nxt < F_MIN) nxt = F_MIN;
            m_acc = nxt;
        end
        m_idx = (m_idx + int'(t)) % 8;
`ifdef TUNE_ACCEL_EN
        exp_accel = (m_run == 4) && ((cyc - last_cnt) < WIN);
`else
        exp_accel = 1'b0;
`endif
    endtask

    // One clock: drive inputs after a negedge, advance the model, compare at the next negedge.
    task automatic step(input bit c, input bit d, input bit t, input bit a);
        cnt = c; dir = d; upd_ack = a;
        if (t) sw_lvl = ~sw_lvl;
        sw_tog = sw_lvl;
        model_edge(c, d, t, a);
        @(posedge clk);
        @(negedge clk);
        check("model_req",   longint'(upd_req),  longint'(m_req));
        check("model_freq",  longint'(freq_out), m_pub);
        check("model_idx",   longint'(step_idx), longint'(m_idx));
        check("model_accel", longint'(accel_on), longint'(exp_accel));
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset();
        cnt = 1'b0; dir = 1'b0; upd_ack = 1'b0; sw_lvl = 1'b0; sw_tog = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_req",   longint'(upd_req),  0);
        check("rst_freq",  longint'(freq_out), F_INIT);
        check("rst_idx",   longint'(step_idx), 3);
        check("rst_accel", longint'(accel_on), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int     tog_n;
        bit     coinc;
        bit     up;
        int     exp_idx;
        longint exp_freq;
    } op_t;

    op_t ops[14];

    initial begin
        ops[0]  = '{4, 1'b0, 1'b1, 7, 17000000};
        ops[1]  = '{0, 1'b0, 1'b1, 7, 27000000};
        ops[2]  = '{0, 1'b0, 1'b1, 7, 30000000};
        ops[3]  = '{0, 1'b0, 1'b0, 7, 20000000};
        ops[4]  = '{0, 1'b0, 1'b0, 7, 10000000};
        ops[5]  = '{0, 1'b0, 1'b0, 7, 100000};
        ops[6]  = '{0, 1'b0, 1'b0, 7, 100000};
        ops[7]  = '{1, 1'b0, 1'b1, 0, 100001};
        ops[8]  = '{3, 1'b0, 1'b1, 3, 101001};
        ops[9]  = '{2, 1'b0, 1'b0, 5, 100000};
        ops[10] = '{1, 1'b0, 1'b1, 6, 1100000};
        ops[11] = '{7, 1'b0, 1'b1, 5, 1200000};
        ops[12] = '{0, 1'b1, 1'b1, 6, 1300000};
        ops[13] = '{0, 1'b0, 1'b1, 6, 2300000};

        rst = 1'b1; cnt = 1'b0; dir = 1'b0; upd_ack = 1'b0; sw_tog = 1'b0; sw_lvl = 1'b0;
        model_reset();
        @(negedge clk);

        // Power-up publish with ack tied high
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("init_req",  longint'(upd_req),  1);
        check("init_freq", longint'(freq_out), F_INIT);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("init_hold", longint'(upd_req), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("init_idle", longint'(upd_req), 0);

        // One step up at idx 3, ack delayed five cycles
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("one_req",  longint'(upd_req),  1);
        check("one_freq", longint'(freq_out), 7001000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("one_stable_req",  longint'(upd_req),  1);
            check("one_stable_freq", longint'(freq_out), 7001000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("one_hold", longint'(upd_req), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("one_idle", longint'(upd_req), 0);

        // Coalescing while ack is withheld, then reset during REQ
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("tog5_idx", longint'(step_idx), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("coal_freq_held", longint'(freq_out), F_INIT);
        check("coal_req_held",  longint'(upd_req),  1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("coal_hold", longint'(upd_req), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("coal_req2",  longint'(upd_req),  1);
        check("coal_freq2", longint'(freq_out), 7000003);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("tog8_wrap_idx", longint'(step_idx), 0);
        do_reset();

        // Table of step/saturation operations from reset
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        foreach (ops[k]) begin
            for (int i = 0; i < ops[k].tog_n; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef TUNE_ACCEL_EN
            idle(int'(WIN), 1'b1);
`endif
            step(1'b1, ops[k].up, ops[k].coinc, 1'b1);
            idle(5, 1'b1);
            check("tbl_freq", longint'(freq_out), ops[k].exp_freq);
            check("tbl_idx",  longint'(step_idx), longint'(ops[k].exp_idx));
        end

`ifdef TUNE_ACCEL_EN
        // Acceleration: run of same-direction steps, then timeout and direction flip
        do_reset();
        idle(3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            idle(9, 1'b1);
        end
        check("acc_freq", longint'(freq_out), 7000019);
        check("acc_on",   longint'(accel_on), 1);
        idle(int'(WIN), 1'b1);
        check("acc_timeout", longint'(accel_on), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            idle(1, 1'b1);
        end
        check("acc_on2", longint'(accel_on), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("acc_flip", longint'(accel_on), 0);
`endif

        // Randomized traffic, with one reset in the middle
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            step(($urandom_range(2) == 0), 1'($urandom), ($urandom_range(7) == 0), 1'($urandom));
        end
        idle(6, 1'b1);
        check("no_step_lost", longint'(freq_out), m_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
